// File: rtl/cussen_pkg.sv
// Shared constants and FSM state type for the cussen multiply scheduler.
package cussen_pkg;
  localparam int W_DEF = 8;
  localparam int N     = 9;
  localparam int IDXW  = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_ISSUE = 2'd2,
    ST_FILL  = 2'd3
  } state_t;
endpackage

// File: rtl/cussen_dedup_table.sv
// Unique-value table: one element per scan cycle, lowest-index match, per-element pointer.
import cussen_pkg::*;

module cussen_dedup_table #(
  parameter int W = W_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clear,
  input  logic                      scan_en,
  input  logic [IDXW-1:0]           scan_idx,
  input  logic [W-1:0]              scan_val,
  input  logic [IDXW-1:0]           rd_idx,
  output logic [W-1:0]              rd_val,
  output logic [IDXW-1:0]           uniq_count,
  output logic [N-1:0][IDXW-1:0]    ptr
);
  logic [W-1:0]           uniq_reg [N];
  logic [IDXW-1:0]        count_reg;
  logic [N-1:0][IDXW-1:0] ptr_reg;
  logic [N-1:0]           hit;
  logic                   match;
  logic [IDXW-1:0]        match_idx;

  // Only entries below the current count are live; stale entries must never match.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_cmp
      assign hit[gi] = (IDXW'(gi) < count_reg) && (uniq_reg[gi] == scan_val);
    end
  endgenerate

  always_comb begin
    match     = |hit;
    match_idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (hit[k]) match_idx = IDXW'(k);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
      ptr_reg   <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (scan_en) begin
      if (match) begin
        ptr_reg[scan_idx] <= match_idx;
      end else begin
        ptr_reg[scan_idx] <= count_reg;
        count_reg         <= count_reg + IDXW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !clear && scan_en && !match) begin
      uniq_reg[count_reg] <= scan_val;
    end
  end

  assign rd_val     = uniq_reg[rd_idx];
  assign uniq_count = count_reg;
  assign ptr        = ptr_reg;
endmodule

// File: rtl/cussen_mul_sched.sv
// Deduplicates a 9-element vector, multiplies each unique value once on a shared
// multiplier, then fans results back out. CUSSEN_SCHED_STATS_EN adds saved_count.
import cussen_pkg::*;

module cussen_mul_sched #(
  parameter int W = W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] in1,
  input  logic [W-1:0] in2,
  input  logic [W-1:0] in3,
  input  logic [W-1:0] in4,
  input  logic [W-1:0] in5,
  input  logic [W-1:0] in6,
  input  logic [W-1:0] in7,
  input  logic [W-1:0] in8,
  input  logic [W-1:0] in9,
  input  logic [W-1:0] scalar,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] out1,
  output logic [W-1:0] out2,
  output logic [W-1:0] out3,
  output logic [W-1:0] out4,
  output logic [W-1:0] out5,
  output logic [W-1:0] out6,
  output logic [W-1:0] out7,
  output logic [W-1:0] out8,
  output logic [W-1:0] out9,
  output logic [3:0]   unique_count,
`ifdef CUSSEN_SCHED_STATS_EN
  output logic [7:0]   saved_count,
`endif
  output logic         mul_req,
  output logic [W-1:0] mul_a,
  output logic [W-1:0] mul_b,
  input  logic         mul_ack,
  input  logic [W-1:0] mul_p
);
  state_t                 state_reg, state_next;
  logic [W-1:0]           in_arr   [N];
  logic [W-1:0]           elem_reg [N];
  logic [W-1:0]           res_reg  [N];
  logic [W-1:0]           out_reg  [N];
  logic [W-1:0]           scalar_reg;
  logic [IDXW-1:0]        cnt_reg;
  logic [IDXW-1:0]        k_reg;
  logic [3:0]             ucount_reg;
  logic                   done_reg;

  logic                   accept;
  logic                   scan_en;
  logic                   hs;
  logic                   last_hs;
  logic                   fill;
  logic [W-1:0]           rd_val;
  logic [IDXW-1:0]        uniq_count;
  logic [N-1:0][IDXW-1:0] ptr;

  assign in_arr[0] = in1;
  assign in_arr[1] = in2;
  assign in_arr[2] = in3;
  assign in_arr[3] = in4;
  assign in_arr[4] = in5;
  assign in_arr[5] = in6;
  assign in_arr[6] = in7;
  assign in_arr[7] = in8;
  assign in_arr[8] = in9;

  cussen_dedup_table #(.W(W)) u_table (
    .clk        (clk),
    .rst        (rst),
    .clear      (accept),
    .scan_en    (scan_en),
    .scan_idx   (cnt_reg),
    .scan_val   (elem_reg[cnt_reg]),
    .rd_idx     (k_reg),
    .rd_val     (rd_val),
    .uniq_count (uniq_count),
    .ptr        (ptr)
  );

  always_ff @(posedge clk) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (start) state_next = ST_SCAN;
      ST_SCAN:  if (cnt_reg == IDXW'(N - 1)) state_next = ST_ISSUE;
      ST_ISSUE: if (last_hs) state_next = ST_FILL;
      ST_FILL:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Operands are gated to zero outside ISSUE so idle/reset outputs are clean.
  always_comb begin
    busy    = (state_reg != ST_IDLE);
    accept  = (state_reg == ST_IDLE) && start;
    scan_en = (state_reg == ST_SCAN);
    fill    = (state_reg == ST_FILL);
    mul_req = (state_reg == ST_ISSUE);
    mul_a   = mul_req ? rd_val : '0;
    mul_b   = mul_req ? scalar_reg : '0;
    hs      = mul_req && mul_ack;
    last_hs = hs && (k_reg == uniq_count - IDXW'(1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg    <= '0;
      k_reg      <= '0;
      scalar_reg <= '0;
      ucount_reg <= '0;
      done_reg   <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (accept) begin
        scalar_reg <= scalar;
        cnt_reg    <= '0;
        k_reg      <= '0;
      end
      if (scan_en) cnt_reg <= cnt_reg + IDXW'(1);
      if (hs)      k_reg   <= k_reg + IDXW'(1);
      if (fill) begin
        ucount_reg <= uniq_count;
        done_reg   <= 1'b1;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_lane
      always_ff @(posedge clk) begin
        if (accept) elem_reg[gi] <= in_arr[gi];
      end

      always_ff @(posedge clk) begin
        if (hs && (k_reg == IDXW'(gi))) res_reg[gi] <= mul_p;
      end

      always_ff @(posedge clk) begin
        if (rst)       out_reg[gi] <= '0;
        else if (fill) out_reg[gi] <= res_reg[ptr[gi]];
      end
    end
  endgenerate

`ifdef CUSSEN_SCHED_STATS_EN
  logic [7:0] saved_reg;
  logic [7:0] saved_inc;
  logic [8:0] saved_sum;

  assign saved_inc = 8'(N) - {4'b0000, uniq_count};
  assign saved_sum = {1'b0, saved_reg} + {1'b0, saved_inc};

  always_ff @(posedge clk) begin
    if (rst)       saved_reg <= '0;
    else if (fill) saved_reg <= saved_sum[8] ? 8'hFF : saved_sum[7:0];
  end

  assign saved_count = saved_reg;
`endif

  assign done         = done_reg;
  assign unique_count = ucount_reg;
  assign out1 = out_reg[0];
  assign out2 = out_reg[1];
  assign out3 = out_reg[2];
  assign out4 = out_reg[3];
  assign out5 = out_reg[4];
  assign out6 = out_reg[5];
  assign out7 = out_reg[6];
  assign out8 = out_reg[7];
  assign out9 = out_reg[8];
endmodule

// File: tb/tb_cussen_mul_sched.sv
// Directed self-checking bench for cussen_mul_sched with a behavioural shared multiplier.
module tb_cussen_mul_sched;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] in_arr [9];
  logic [7:0] scalar;
  logic       busy, done;
  logic [7:0] out_arr [9];
  logic [3:0] unique_count;
  logic       mul_req;
  logic [7:0] mul_a, mul_b, mul_p;
  logic       mul_ack = 1'b1;
`ifdef CUSSEN_SCHED_STATS_EN
  logic [7:0] saved_count;
`endif

  int   checks = 0;
  int   errors = 0;
  int   hs_total = 0;
  int   done_total = 0;
  int   stab_viol = 0;
  int   wait_cnt = 0;
  bit   ack_delay = 0;
  bit   pend = 0;
  logic [7:0] pa, pb;

  always #5 clk = ~clk;

  assign mul_p = mul_a * mul_b;

  cussen_mul_sched dut (
    .clk(clk), .rst(rst), .start(start),
    .in1(in_arr[0]), .in2(in_arr[1]), .in3(in_arr[2]), .in4(in_arr[3]), .in5(in_arr[4]),
    .in6(in_arr[5]), .in7(in_arr[6]), .in8(in_arr[7]), .in9(in_arr[8]),
    .scalar(scalar), .busy(busy), .done(done),
    .out1(out_arr[0]), .out2(out_arr[1]), .out3(out_arr[2]), .out4(out_arr[3]), .out5(out_arr[4]),
    .out6(out_arr[5]), .out7(out_arr[6]), .out8(out_arr[7]), .out9(out_arr[8]),
    .unique_count(unique_count),
`ifdef CUSSEN_SCHED_STATS_EN
    .saved_count(saved_count),
`endif
    .mul_req(mul_req), .mul_a(mul_a), .mul_b(mul_b), .mul_ack(mul_ack), .mul_p(mul_p)
  );

  // Multiplier model: ack either tied high or after 3 waiting cycles; also tracks handshakes.
  always @(negedge clk) begin
    if (ack_delay) begin
      if (mul_req) begin
        if (wait_cnt == 3) begin mul_ack = 1'b1; wait_cnt = 0; end
        else begin mul_ack = 1'b0; wait_cnt++; end
      end else begin
        mul_ack = 1'b0; wait_cnt = 0;
      end
    end else begin
      mul_ack = 1'b1;
    end
    if (mul_req && pend && (mul_a !== pa || mul_b !== pb)) stab_viol++;
    pend = mul_req && !mul_ack;
    pa = mul_a;
    pb = mul_b;
    if (mul_req && mul_ack) hs_total++;
    if (done === 1'b1) done_total++;
  end

  task automatic load(input logic [71:0] v, input logic [7:0] s);
    for (int i = 0; i < 9; i++) in_arr[i] = v[71-8*i -: 8];
    scalar = s;
  endtask

  // Called #1 after a rising edge with the DUT idle; returns edges from accept to done.
  task automatic start_and_wait(input bit poke, output int lat);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 9; i++) in_arr[i] = 8'($urandom);
    scalar = 8'($urandom);
    lat = 0;
    while (lat < 400) begin
      @(posedge clk); #1;
      lat++;
      if (done === 1'b1) break;
      start = (poke && lat == 4);
    end
    start = 1'b0;
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL timeout: done got %b want 1 after %0d cycles", done, lat);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks += 7;
    if (busy !== 1'b0)         begin errors++; $display("FAIL reset busy: got %b want 0", busy); end
    if (done !== 1'b0)         begin errors++; $display("FAIL reset done: got %b want 0", done); end
    if (mul_req !== 1'b0)      begin errors++; $display("FAIL reset mul_req: got %b want 0", mul_req); end
    if (mul_a !== 8'd0)        begin errors++; $display("FAIL reset mul_a: got %0d want 0", mul_a); end
    if (mul_b !== 8'd0)        begin errors++; $display("FAIL reset mul_b: got %0d want 0", mul_b); end
    if (unique_count !== 4'd0) begin errors++; $display("FAIL reset unique_count: got %0d want 0", unique_count); end
    if (out_arr[4] !== 8'd0)   begin errors++; $display("FAIL reset out5: got %0d want 0", out_arr[4]); end
`ifdef CUSSEN_SCHED_STATS_EN
    checks++;
    if (saved_count !== 8'd0)  begin errors++; $display("FAIL reset saved_count: got %0d want 0", saved_count); end
`endif
    rst = 1'b0;
    @(posedge clk); #1;
    $display("reset: busy=%b done=%b mul_req=%b", busy, done, mul_req);
  endtask

  task automatic test_small();
    int lat, h0;
    logic [71:0] exp = {8'd54, 8'd6, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    load({8'd9, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0}, 8'd6);
    h0 = hs_total;
    start_and_wait(1'b0, lat);
    $display("small: lat=%0d uc=%0d hs=%0d", lat, unique_count, hs_total - h0);
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (out_arr[i] !== exp[71-8*i -: 8]) begin errors++; $display("FAIL small out%0d: got %0d want %0d", i+1, out_arr[i], exp[71-8*i -: 8]); end
    end
    checks += 3;
    if (unique_count !== 4'd3) begin errors++; $display("FAIL small unique_count: got %0d want 3", unique_count); end
    if (lat != 13)             begin errors++; $display("FAIL small latency: got %0d want 13", lat); end
    if (hs_total - h0 != 3)    begin errors++; $display("FAIL small handshakes: got %0d want 3", hs_total - h0); end
    @(posedge clk); #1;
    checks += 2;
    if (done !== 1'b0) begin errors++; $display("FAIL small done pulse: got %b want 0", done); end
    if (out_arr[0] !== 8'd54) begin errors++; $display("FAIL small hold out1: got %0d want 54", out_arr[0]); end
  endtask

  task automatic test_all_unique();
    int lat, h0;
    logic [71:0] exp = {8'd10, 8'd6, 8'd16, 8'd2, 8'd4, 8'd18, 8'd14, 8'd12, 8'd8};
    load({8'd5, 8'd3, 8'd8, 8'd1, 8'd2, 8'd9, 8'd7, 8'd6, 8'd4}, 8'd2);
    h0 = hs_total;
    start_and_wait(1'b0, lat);
    $display("all_unique: lat=%0d uc=%0d hs=%0d", lat, unique_count, hs_total - h0);
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (out_arr[i] !== exp[71-8*i -: 8]) begin errors++; $display("FAIL all_unique out%0d: got %0d want %0d", i+1, out_arr[i], exp[71-8*i -: 8]); end
    end
    checks += 3;
    if (unique_count !== 4'd9) begin errors++; $display("FAIL all_unique unique_count: got %0d want 9", unique_count); end
    if (lat != 19)             begin errors++; $display("FAIL all_unique latency: got %0d want 19", lat); end
    if (hs_total - h0 != 9)    begin errors++; $display("FAIL all_unique handshakes: got %0d want 9", hs_total - h0); end
  endtask

  // Duplicate-heavy vector followed immediately by a start in the done cycle.
  task automatic test_back_to_back();
    int lat, h0;
    logic [71:0] exp = {8'd6, 8'd2, 8'd8, 8'd2, 8'd10, 8'd18, 8'd2, 8'd2, 8'd2};
    @(posedge clk); #1;
    load({8'd3, 8'd1, 8'd4, 8'd1, 8'd5, 8'd9, 8'd1, 8'd1, 8'd1}, 8'd2);
    h0 = hs_total;
    start_and_wait(1'b0, lat);
    $display("dups: lat=%0d uc=%0d hs=%0d", lat, unique_count, hs_total - h0);
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (out_arr[i] !== exp[71-8*i -: 8]) begin errors++; $display("FAIL dups out%0d: got %0d want %0d", i+1, out_arr[i], exp[71-8*i -: 8]); end
    end
    checks += 3;
    if (unique_count !== 4'd5) begin errors++; $display("FAIL dups unique_count: got %0d want 5", unique_count); end
    if (lat != 15)             begin errors++; $display("FAIL dups latency: got %0d want 15", lat); end
    if (hs_total - h0 != 5)    begin errors++; $display("FAIL dups handshakes: got %0d want 5", hs_total - h0); end
    load({8'd7, 8'd7, 8'd7, 8'd7, 8'd7, 8'd7, 8'd7, 8'd7, 8'd7}, 8'd3);
    start_and_wait(1'b0, lat);
    $display("back_to_back: lat=%0d uc=%0d out1=%0d", lat, unique_count, out_arr[0]);
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (out_arr[i] !== 8'd21) begin errors++; $display("FAIL b2b out%0d: got %0d want 21", i+1, out_arr[i]); end
    end
    checks += 2;
    if (unique_count !== 4'd1) begin errors++; $display("FAIL b2b unique_count: got %0d want 1", unique_count); end
    if (lat != 11)             begin errors++; $display("FAIL b2b latency: got %0d want 11", lat); end
  endtask

  task automatic test_delayed_ack();
    int lat, h0, s0;
    logic [71:0] exp = {8'd6, 8'd2, 8'd8, 8'd2, 8'd10, 8'd18, 8'd2, 8'd2, 8'd2};
    @(posedge clk); #1;
    ack_delay = 1'b1;
    load({8'd3, 8'd1, 8'd4, 8'd1, 8'd5, 8'd9, 8'd1, 8'd1, 8'd1}, 8'd2);
    h0 = hs_total;
    s0 = stab_viol;
    start_and_wait(1'b1, lat);
    $display("delayed_ack: lat=%0d uc=%0d hs=%0d", lat, unique_count, hs_total - h0);
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (out_arr[i] !== exp[71-8*i -: 8]) begin errors++; $display("FAIL delayed out%0d: got %0d want %0d", i+1, out_arr[i], exp[71-8*i -: 8]); end
    end
    checks += 4;
    if (unique_count !== 4'd5) begin errors++; $display("FAIL delayed unique_count: got %0d want 5", unique_count); end
    if (hs_total - h0 != 5)    begin errors++; $display("FAIL delayed handshakes: got %0d want 5", hs_total - h0); end
    if (stab_viol != s0)       begin errors++; $display("FAIL delayed operand stability: got %0d changes want 0", stab_viol - s0); end
    if (lat <= 15)             begin errors++; $display("FAIL delayed latency: got %0d want above 15", lat); end
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL delayed busy after done: got %b want 0", busy); end
    ack_delay = 1'b0;
  endtask

  task automatic test_reset_mid();
    int lat, d0, n;
    d0 = done_total;
    ack_delay = 1'b1;
    load({8'd3, 8'd1, 8'd4, 8'd1, 8'd5, 8'd9, 8'd1, 8'd1, 8'd1}, 8'd2);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (mul_req !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    checks++;
    if (mul_req !== 1'b1) begin errors++; $display("FAIL reset_mid reach issue: mul_req got %b want 1", mul_req); end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    checks += 3;
    if (mul_req !== 1'b0) begin errors++; $display("FAIL reset_mid mul_req: got %b want 0", mul_req); end
    if (busy !== 1'b0)    begin errors++; $display("FAIL reset_mid busy: got %b want 0", busy); end
    if (mul_a !== 8'd0)   begin errors++; $display("FAIL reset_mid mul_a: got %0d want 0", mul_a); end
    rst = 1'b0;
    ack_delay = 1'b0;
    @(posedge clk); #1;
    load({8'd200, 8'd200, 8'd200, 8'd200, 8'd200, 8'd200, 8'd200, 8'd200, 8'd200}, 8'd2);
    start_and_wait(1'b0, lat);
    $display("reset_mid: lat=%0d uc=%0d out1=%0d", lat, unique_count, out_arr[0]);
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (out_arr[i] !== 8'd144) begin errors++; $display("FAIL reset_mid out%0d: got %0d want 144", i+1, out_arr[i]); end
    end
    checks += 2;
    if (unique_count !== 4'd1) begin errors++; $display("FAIL reset_mid unique_count: got %0d want 1", unique_count); end
    if (lat != 11)             begin errors++; $display("FAIL reset_mid latency: got %0d want 11", lat); end
`ifdef CUSSEN_SCHED_STATS_EN
    checks++;
    if (saved_count !== 8'd8) begin errors++; $display("FAIL reset_mid saved_count: got %0d want 8", saved_count); end
`endif
    @(negedge clk); #1;
    checks++;
    if (done_total != d0 + 1) begin errors++; $display("FAIL reset_mid done pulses: got %0d want 1", done_total - d0); end
  endtask

  initial begin
    for (int i = 0; i < 9; i++) in_arr[i] = 8'd0;
    scalar = 8'd0;
    test_reset();
    test_small();
    test_all_unique();
    test_back_to_back();
    test_delayed_ack();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/cussen_mul_sched.md
CUSSEN_MUL_SCHED -- requirements
Module: cussen_mul_sched

Interface
REQ-001 Parameter: W, 8, data width of inputs, scalar, products and outputs.
REQ-002 One clock; reset is synchronous and active-high.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 start  input  1  request to process one 9-element vector; sampled only in IDLE.
REQ-006 in1..in9  input  W each  vector elements, captured on the accepting edge.
REQ-007 scalar  input  W  multiplier operand, captured on the accepting edge.
REQ-008 busy  output  1  high in every state except IDLE.
REQ-009 done  output  1  one-cycle pulse; new results are valid.
REQ-010 out1..out9  output  W each  registered results, held until the next done.
REQ-011 unique_count  output  4  number of distinct elements in the last completed vector.
REQ-012 mul_req  output  1  request to the shared multiplier.
REQ-013 mul_a, mul_b  output  W each  operands: unique value and captured scalar.
REQ-014 mul_ack  input  1  multiplier accepts; mul_p valid in the same cycle.
REQ-015 mul_p  input  W  product, low W bits.

Function
REQ-016 States: IDLE, SCAN, ISSUE, FILL; IDLE->SCAN on start, SCAN->ISSUE after 9 cycles, ISSUE->FILL after the last handshake, FILL->IDLE.
REQ-017 SCAN processes element i (1..9) in cycle i: compare against unique entries 0..U-1; on match ptr[i]=match index, else append at U, ptr[i]=U, U++.
REQ-018 Value 0 is an ordinary value; identical values always map to the lowest matching index.
REQ-019 ISSUE: for k=0..U-1 in order, drive mul_req=1, mul_a=uniq[k], mul_b=scalar; hold all three stable until mul_req&&mul_ack.
REQ-020 On the handshake cycle, store mul_p into res[k]; the next request may be driven the following cycle.
REQ-021 Exactly U handshakes per vector; mul_ack while mul_req=0 is ignored.
REQ-022 FILL: outK <= res[ptr[K]] for all K, unique_count <= U, done <= 1 on the same edge; done low the next cycle.
REQ-023 Latency with mul_ack tied high: done rises at edge 10+U after the edge that sampled start; U ranges 1..9.
REQ-024 start while busy is ignored; start in the cycle done is high is accepted (state is IDLE).
REQ-025 Input changes after the accepting edge do not affect the result in flight.

Reset
REQ-026 While rst is high: state=IDLE, busy=0, done=0, mul_req=0, mul_a=mul_b=0, out1..out9=0, unique_count=0, U=0.
REQ-027 Reset mid-operation abandons the vector; no done is produced and mul_req drops on the reset edge.

Configuration
REQ-028 Macro CUSSEN_SCHED_STATS_EN defined: adds output saved_count (8 bits), accumulating 9-U at each done, saturating at 255, cleared by rst.
REQ-029 Macro undefined: port saved_count and its logic are absent; all other behaviour is identical.

Structure
REQ-030 Package cussen_pkg holds W default, element count N=9, index width 4 and the state enum.
REQ-031 Sub-module cussen_dedup_table holds the unique-value table, match compare and pointer array; the FSM and multiplier handshake stay in cussen_mul_sched.

Verification
REQ-032 in=9,1,0,0,0,0,0,0,0 scalar=6, ack tied high -> out=54,6,0,0,0,0,0,0,0; unique_count=3; done at edge 13.
REQ-033 in=5,3,8,1,2,9,7,6,4 scalar=2 -> out=10,6,16,2,4,18,14,12,8; U=9; 9 handshakes.
REQ-034 in=3,1,4,1,5,9,1,1,1 scalar=2 -> out=6,2,8,2,10,18,2,2,2; U=5; exactly 5 handshakes.
REQ-035 mul_ack delayed 3 cycles per request -> mul_a and mul_b stable while waiting; results as in REQ-034; start during busy ignored.
REQ-036 rst asserted during ISSUE, then start with all elements 200 and scalar=2 (model returns low 8 bits) -> no done before the new run; out all 144; U=1; saved_count=8 with macro defined.
